// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive front end: FSM state
// encoding, counter width derivation and the 2-of-3 majority vote.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Stop-bit counter only ever needs to reach STOP_BITS-1 (at most 1).
  localparam int unsigned STOP_CNT_W = 2;

  // Width of a counter that must hold values 0..n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic maj3(input logic [2:0] h);
    return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
  endfunction

endpackage

// File: rtl/uart_rx_frame_detect_if.sv
// Downstream side of the receive front end: per-bit strobes, frame status
// and the abort/ack returned by the character assembler.
interface uart_rx_frame_detect_if
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = 8
);
  localparam int unsigned IDX_W = cnt_w(DATA_BITS + 1);

  logic             receive_enable;
  logic             bit_strobe;
  logic             bit_value;
  logic [IDX_W-1:0] bit_index;
  logic             frame_done;
  logic             false_start;
  logic             framing_error;
  logic             break_detect;
  logic             char_received;

  modport master (
    output receive_enable, bit_strobe, bit_value, bit_index,
           frame_done, false_start, framing_error, break_detect,
    input  char_received
  );

  modport slave (
    input  receive_enable, bit_strobe, bit_value, bit_index,
           frame_done, false_start, framing_error, break_detect,
    output char_received
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Line conditioning: metastability synchroniser, tick-gated 3-sample
// history with majority vote, and the idle-to-start falling-edge flag.
module uart_rx_sync
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_tick,
  input  logic data_in,
  output logic line,
  output logic maj,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      hist_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
      if (sample_tick) hist_q <= {hist_q[1:0], line};
    end
  end

  assign line = sync_q[SYNC_STAGES-1];
  assign maj  = maj3(hist_q);
  // hist_q[0] is the previous tick's sample, so a held-low line never re-fires.
  assign fall = sample_tick & ~line & hist_q[0];

endmodule

// File: rtl/uart_rx_frame_detect.sv
// UART receive frame sequencer: validates the start bit at mid-bit, strobes
// each data/parity bit at its centre, samples the stop bits and flags errors.
module uart_rx_frame_detect
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_tick,
  input  logic data_in,
  uart_rx_frame_detect_if.master rx
);

  localparam int unsigned NBITS = DATA_BITS + PARITY_EN;
  localparam int unsigned OS_W  = cnt_w(OVERSAMPLE);
  localparam int unsigned IDX_W = cnt_w(DATA_BITS + 1);

  localparam logic [OS_W-1:0]       OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]       HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0]      BIT_LAST  = IDX_W'(NBITS - 1);
  localparam logic [IDX_W-1:0]      DATA_LIM  = IDX_W'(DATA_BITS);
  localparam logic [STOP_CNT_W-1:0] SB_LAST   = STOP_CNT_W'(STOP_BITS - 1);

  logic line_s, maj, fall;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .data_in     (data_in),
    .line        (line_s),
    .maj         (maj),
    .fall        (fall)
  );

  rx_state_e              state_q, state_d;
  logic [OS_W-1:0]        os_q, os_d;
  logic [IDX_W-1:0]       bit_q, bit_d;
  logic [STOP_CNT_W-1:0]  stop_q, stop_d;
  logic                   zero_q, zero_d;
  logic                   serr_q, serr_d;
  logic                   re_q, re_d, strobe_q, strobe_d, val_q, val_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   done_q, done_d, fs_q, fs_d, fe_q, fe_d, brk_q, brk_d;
  logic                   abort;

  assign abort = rx.char_received & (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Abort outranks any tick event in the same cycle.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else if (sample_tick) begin
      unique case (state_q)
        IDLE:    if (fall) state_d = START;
        START:   if (os_q == HALF_LAST) state_d = maj ? IDLE : DATA;
        DATA:    if (os_q == OS_LAST && bit_q == BIT_LAST) state_d = STOP;
        STOP:    if (os_q == OS_LAST && stop_q == SB_LAST) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    os_d     = os_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    zero_d   = zero_q;
    serr_d   = serr_q;
    re_d     = re_q;
    strobe_d = 1'b0;
    val_d    = val_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    fs_d     = 1'b0;
    fe_d     = 1'b0;
    brk_d    = line_s ? 1'b0 : brk_q;
    if (abort) begin
      os_d   = '0;
      bit_d  = '0;
      stop_d = '0;
      re_d   = 1'b0;
    end else if (sample_tick) begin
      unique case (state_q)
        IDLE: if (fall) os_d = '0;
        START: begin
          if (os_q == HALF_LAST) begin
            os_d = '0;
            if (!maj) begin
              bit_d  = '0;
              zero_d = 1'b1;
              re_d   = 1'b1;
            end else begin
              fs_d = 1'b1;
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
        DATA: begin
          if (os_q == OS_LAST) begin
            os_d     = '0;
            strobe_d = 1'b1;
            val_d    = maj;
            idx_d    = bit_q;
            // Parity position is excluded from the break qualification.
            if (bit_q < DATA_LIM && maj) zero_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              stop_d = '0;
              serr_d = 1'b0;
            end else begin
              bit_d = bit_q + IDX_W'(1);
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
        STOP: begin
          if (os_q == OS_LAST) begin
            os_d = '0;
            if (!maj) serr_d = 1'b1;
            if (stop_q == SB_LAST) begin
              done_d = 1'b1;
              re_d   = 1'b0;
              fe_d   = serr_q | ~maj;
              if ((serr_q | ~maj) && zero_q) brk_d = 1'b1;
            end else begin
              stop_d = stop_q + STOP_CNT_W'(1);
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      os_q     <= '0;
      bit_q    <= '0;
      stop_q   <= '0;
      zero_q   <= 1'b0;
      serr_q   <= 1'b0;
      re_q     <= 1'b0;
      strobe_q <= 1'b0;
      val_q    <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      fs_q     <= 1'b0;
      fe_q     <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      os_q     <= os_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      zero_q   <= zero_d;
      serr_q   <= serr_d;
      re_q     <= re_d;
      strobe_q <= strobe_d;
      val_q    <= val_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      fs_q     <= fs_d;
      fe_q     <= fe_d;
      brk_q    <= brk_d;
    end
  end

  assign rx.receive_enable = re_q;
  assign rx.bit_strobe     = strobe_q;
  assign rx.bit_value      = val_q;
  assign rx.bit_index      = idx_q;
  assign rx.frame_done     = done_q;
  assign rx.false_start    = fs_q;
  assign rx.framing_error  = fe_q;
  assign rx.break_detect   = brk_q;

endmodule

// File: tb/tb_uart_rx_frame_detect.sv
// Directed bench: 8N1 receiver (dut_a) and a 7-bit parity, two-stop
// receiver (dut_b) sharing clock, reset and a sample tick at clk/4.
module tb_uart_rx_frame_detect;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sample_tick = 1'b0;
  logic data_a = 1'b1;
  logic data_b = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;
  int tick_cnt = 0;

  uart_rx_frame_detect_if #(.DATA_BITS(8)) if_a ();
  uart_rx_frame_detect_if #(.DATA_BITS(7)) if_b ();

  uart_rx_frame_detect #(
    .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1), .SYNC_STAGES(2)
  ) dut_a (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .data_in(data_a), .rx(if_a)
  );

  uart_rx_frame_detect #(
    .OVERSAMPLE(16), .DATA_BITS(7), .PARITY_EN(1), .STOP_BITS(2), .SYNC_STAGES(2)
  ) dut_b (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .data_in(data_b), .rx(if_b)
  );

  always #5 clk = ~clk;

  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      sample_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  always @(posedge clk) if (sample_tick) tick_cnt++;

  // Event recorders for dut_a
  logic str_val [0:255];
  int   str_idx [0:255];
  int   str_cnt = 0, last_str_tick = 0, re_low_str = 0, re_hi_cyc = 0;
  int   fd_cnt = 0, fd_tick = 0, fe_cnt = 0, fe_alone = 0, fs_cnt = 0;

  always @(negedge clk) begin
    if (if_a.bit_strobe) begin
      if (str_cnt < 256) begin
        str_val[str_cnt] = if_a.bit_value;
        str_idx[str_cnt] = int'(if_a.bit_index);
      end
      if (!if_a.receive_enable) re_low_str++;
      str_cnt++;
      last_str_tick = tick_cnt;
    end
    if (if_a.frame_done) begin
      fd_cnt++;
      fd_tick = tick_cnt;
    end
    if (if_a.framing_error) begin
      fe_cnt++;
      if (!if_a.frame_done) fe_alone++;
    end
    if (if_a.false_start) fs_cnt++;
    if (if_a.receive_enable) re_hi_cyc++;
  end

  // Event recorders for dut_b
  int   b_str_cnt = 0, b_last_idx = -1, b_last_str_tick = 0;
  logic b_last_val = 1'b0;
  int   b_fd_cnt = 0, b_fd_tick = 0, b_fe_cnt = 0;

  always @(negedge clk) begin
    if (if_b.bit_strobe) begin
      b_str_cnt++;
      b_last_idx = int'(if_b.bit_index);
      b_last_val = if_b.bit_value;
      b_last_str_tick = tick_cnt;
    end
    if (if_b.frame_done) begin
      b_fd_cnt++;
      b_fd_tick = tick_cnt;
    end
    if (if_b.framing_error) b_fe_cnt++;
  end

  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (sample_tick) c++;
    end
    #1;
  endtask

  // Bits go out LSB first, each held for 16 ticks.
  task automatic send_bits(input logic [15:0] bits, input int n, input bit sel_b);
    for (int i = 0; i < n; i++) begin
      if (sel_b) data_b = bits[i];
      else       data_a = bits[i];
      wait_ticks(16);
    end
  endtask

  task automatic test_reset();
    logic [10:0] va;
    logic [9:0]  vb;
    reset = 1'b0;
    if_a.char_received = 1'b0;
    if_b.char_received = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    va = {if_a.receive_enable, if_a.bit_strobe, if_a.bit_value, if_a.bit_index,
          if_a.frame_done, if_a.false_start, if_a.framing_error, if_a.break_detect};
    vb = {if_b.receive_enable, if_b.bit_strobe, if_b.bit_value, if_b.bit_index,
          if_b.frame_done, if_b.false_start, if_b.framing_error, if_b.break_detect};
    tests_run++;
    if (va !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs_a: got %b want 0", va);
    end
    tests_run++;
    if (vb !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs_b: got %b want 0", vb);
    end
    @(negedge clk);
    reset = 1'b1;
    wait_ticks(20);
    tests_run++;
    if (if_a.receive_enable !== 1'b0 || fs_cnt !== 0 || str_cnt !== 0) begin
      tests_failed++;
      $display("FAIL idle_quiet: got re=%b fs=%0d str=%0d want 0/0/0",
               if_a.receive_enable, fs_cnt, str_cnt);
    end
  endtask

  task automatic test_clean_frame();
    int bs, bfd, bfe, brl;
    logic [7:0] d;
    d = 8'hA5;
    bs = str_cnt; bfd = fd_cnt; bfe = fe_cnt; brl = re_low_str;
    send_bits({6'd0, 1'b1, d, 1'b0}, 10, 1'b0);
    wait_ticks(16);
    tests_run++;
    if (str_cnt - bs !== 8) begin
      tests_failed++;
      $display("FAIL clean_strobe_count: got %0d want 8", str_cnt - bs);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (str_val[bs+i] !== d[i] || str_idx[bs+i] !== i) begin
        tests_failed++;
        $display("FAIL clean_bit%0d: got val=%b idx=%0d want val=%b idx=%0d",
                 i, str_val[bs+i], str_idx[bs+i], d[i], i);
      end
    end
    tests_run++;
    if (fd_cnt - bfd !== 1 || fe_cnt - bfe !== 0) begin
      tests_failed++;
      $display("FAIL clean_done: got done=%0d ferr=%0d want 1/0", fd_cnt - bfd, fe_cnt - bfe);
    end
    tests_run++;
    if (re_low_str - brl !== 0) begin
      tests_failed++;
      $display("FAIL clean_re_high: got %0d strobes with re=0 want 0", re_low_str - brl);
    end
    tests_run++;
    if (fd_tick - last_str_tick !== 16) begin
      tests_failed++;
      $display("FAIL clean_stop_timing: got %0d ticks want 16", fd_tick - last_str_tick);
    end
  endtask

  task automatic test_glitch();
    int bs, bfs, bre;
    bs = str_cnt; bfs = fs_cnt; bre = re_hi_cyc;
    data_a = 1'b0;
    wait_ticks(3);
    data_a = 1'b1;
    wait_ticks(24);
    tests_run++;
    if (fs_cnt - bfs !== 1) begin
      tests_failed++;
      $display("FAIL glitch_false_start: got %0d want 1", fs_cnt - bfs);
    end
    tests_run++;
    if (str_cnt - bs !== 0 || re_hi_cyc - bre !== 0) begin
      tests_failed++;
      $display("FAIL glitch_quiet: got str=%0d re_cycles=%0d want 0/0",
               str_cnt - bs, re_hi_cyc - bre);
    end
  endtask

  task automatic test_break();
    int bs, bfd, bfe, bfa, bfs;
    bs = str_cnt; bfd = fd_cnt; bfe = fe_cnt; bfa = fe_alone; bfs = fs_cnt;
    send_bits(16'd0, 10, 1'b0);
    wait_ticks(20 * 16);
    tests_run++;
    if (fe_cnt - bfe !== 1 || fd_cnt - bfd !== 1 || fe_alone - bfa !== 0) begin
      tests_failed++;
      $display("FAIL break_ferr: got ferr=%0d done=%0d unpaired=%0d want 1/1/0",
               fe_cnt - bfe, fd_cnt - bfd, fe_alone - bfa);
    end
    tests_run++;
    if (if_a.break_detect !== 1'b1) begin
      tests_failed++;
      $display("FAIL break_set: got %b want 1", if_a.break_detect);
    end
    tests_run++;
    if (str_cnt - bs !== 8 || fs_cnt - bfs !== 0 || if_a.receive_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL break_no_retrigger: got str=%0d fs=%0d re=%b want 8/0/0",
               str_cnt - bs, fs_cnt - bfs, if_a.receive_enable);
    end
    data_a = 1'b1;
    wait_ticks(2);
    tests_run++;
    if (if_a.break_detect !== 1'b0) begin
      tests_failed++;
      $display("FAIL break_clear: got %b want 0", if_a.break_detect);
    end
    wait_ticks(16);
  endtask

  task automatic test_parity_two_stop();
    int bs, bfd, bfe;
    logic [6:0] d;
    d = 7'h55;
    bs = b_str_cnt; bfd = b_fd_cnt; bfe = b_fe_cnt;
    send_bits({5'd0, 2'b11, 1'b1, d, 1'b0}, 11, 1'b1);
    wait_ticks(16);
    tests_run++;
    if (b_str_cnt - bs !== 8 || b_last_idx !== 7 || b_last_val !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_strobes: got n=%0d last_idx=%0d last_val=%b want 8/7/1",
               b_str_cnt - bs, b_last_idx, b_last_val);
    end
    tests_run++;
    if (b_fd_cnt - bfd !== 1 || b_fe_cnt - bfe !== 0) begin
      tests_failed++;
      $display("FAIL parity_done: got done=%0d ferr=%0d want 1/0", b_fd_cnt - bfd, b_fe_cnt - bfe);
    end
    tests_run++;
    if (b_fd_tick - b_last_str_tick !== 32) begin
      tests_failed++;
      $display("FAIL parity_stop_timing: got %0d ticks want 32", b_fd_tick - b_last_str_tick);
    end
  endtask

  task automatic test_abort();
    int bs, bfd, bfe, guard;
    logic re_before, re_after, timed_out;
    logic [7:0] d;
    bs = str_cnt; bfd = fd_cnt; bfe = fe_cnt;
    re_before = 1'b0; re_after = 1'b1; timed_out = 1'b0;
    // Bits after index 3 are all 1, so no falling edge can restart the machine.
    fork
      send_bits({6'd0, 1'b1, 8'hF5, 1'b0}, 10, 1'b0);
      begin
        guard = 0;
        while (str_cnt < bs + 4 && guard < 5000) begin
          @(posedge clk);
          guard++;
        end
        timed_out = (guard >= 5000);
        #1;
        re_before = if_a.receive_enable;
        if_a.char_received = 1'b1;
        @(posedge clk);
        #1;
        if_a.char_received = 1'b0;
        re_after = if_a.receive_enable;
      end
    join
    wait_ticks(16);
    tests_run++;
    if (timed_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_wait: got timeout=%b want 0", timed_out);
    end
    tests_run++;
    if (re_before !== 1'b1 || re_after !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_re: got before=%b after=%b want 1/0", re_before, re_after);
    end
    tests_run++;
    if (str_cnt - bs !== 4 || fd_cnt - bfd !== 0 || fe_cnt - bfe !== 0) begin
      tests_failed++;
      $display("FAIL abort_quiet: got str=%0d done=%0d ferr=%0d want 4/0/0",
               str_cnt - bs, fd_cnt - bfd, fe_cnt - bfe);
    end
    d = 8'h3C;
    bs = str_cnt; bfd = fd_cnt;
    send_bits({6'd0, 1'b1, d, 1'b0}, 10, 1'b0);
    wait_ticks(16);
    tests_run++;
    if (str_cnt - bs !== 8 || fd_cnt - bfd !== 1) begin
      tests_failed++;
      $display("FAIL abort_next_frame: got str=%0d done=%0d want 8/1", str_cnt - bs, fd_cnt - bfd);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (str_val[bs+i] !== d[i] || str_idx[bs+i] !== i) begin
        tests_failed++;
        $display("FAIL abort_next_bit%0d: got val=%b idx=%0d want val=%b idx=%0d",
                 i, str_val[bs+i], str_idx[bs+i], d[i], i);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int bs, bfd, bfe;
    logic [10:0] va;
    logic [7:0] d;
    bs = str_cnt;
    send_bits(16'b1010, 4, 1'b0);
    tests_run++;
    if (str_cnt - bs !== 3 || if_a.receive_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_pre: got str=%0d re=%b want 3/1", str_cnt - bs, if_a.receive_enable);
    end
    #3;
    reset = 1'b0;
    #1;
    va = {if_a.receive_enable, if_a.bit_strobe, if_a.bit_value, if_a.bit_index,
          if_a.frame_done, if_a.false_start, if_a.framing_error, if_a.break_detect};
    tests_run++;
    if (va !== 11'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %b want 0", va);
    end
    data_a = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    d = 8'h5A;
    bs = str_cnt; bfd = fd_cnt; bfe = fe_cnt;
    send_bits({6'd0, 1'b1, d, 1'b0}, 10, 1'b0);
    wait_ticks(16);
    tests_run++;
    if (str_cnt - bs !== 8 || fd_cnt - bfd !== 1 || fe_cnt - bfe !== 0) begin
      tests_failed++;
      $display("FAIL midreset_frame: got str=%0d done=%0d ferr=%0d want 8/1/0",
               str_cnt - bs, fd_cnt - bfd, fe_cnt - bfe);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (str_val[bs+i] !== d[i] || str_idx[bs+i] !== i) begin
        tests_failed++;
        $display("FAIL midreset_bit%0d: got val=%b idx=%0d want val=%b idx=%0d",
                 i, str_val[bs+i], str_idx[bs+i], d[i], i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_glitch();
    test_break();
    test_parity_two_stop();
    test_abort();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_detect.md
# uart_rx_frame_detect

Parametrised UART receive front end that succeeds the single-bit start detector. It synchronises the serial line and detects and validates the start bit by mid-bit majority vote. It then sequences the data, parity and stop bits of one frame, giving the shift register a mid-bit strobe for every payload bit. It sits between the pad-side `data_in` line and the receive shift register/character assembler, on the shared oversampling tick.

## Interface
- `OVERSAMPLE`, 16: sample ticks per bit; even, ≥ 4.
- `DATA_BITS`, 8: payload bits per frame, 5–9.
- `PARITY_EN`, 0: 1 adds one parity bit after the data; it is strobed, not checked here.
- `STOP_BITS`, 1: 1 or 2.
- `SYNC_STAGES`, 2: synchroniser depth, ≥ 2.
- `clk` in 1: the single clock; rising edge.
- `reset` in 1: asynchronous, active-low.
- `sample_tick` in 1: one-`clk` enable at `OVERSAMPLE`× baud.
- `data_in` in 1: raw serial line, idle high.
- `char_received` in 1: downstream abort/ack; forces IDLE.
- `receive_enable` out 1: high from validated start until frame end.
- `bit_strobe` out 1: one-`clk` pulse at mid-bit of each data/parity bit.
- `bit_value` out 1: majority value of the strobed bit; valid with `bit_strobe`.
- `bit_index` out `$clog2(DATA_BITS+1)`: index of the strobed bit; the first data bit is 0 and parity is `DATA_BITS`.
- `frame_done` out 1: one-`clk` pulse after the last stop sample.
- `false_start` out 1: one-`clk` pulse when a start bit is rejected.
- `framing_error` out 1: one-`clk` pulse, coincident with `frame_done`, if any stop sample is 0.
- `break_detect` out 1: level, set on framing error with all data bits 0; clears when the synchronised line returns to 1.

## Operation
- Synchroniser: `data_in` passes through `SYNC_STAGES` flops that reset to 1.
- History: on each `sample_tick`, the synchronised value shifts into a 3-deep history that resets to 3'b111. The majority is 2-of-3 of this history.
- `NBITS` = `DATA_BITS` + `PARITY_EN`.
- The state machine advances only on cycles where `sample_tick` = 1. The `char_received` abort applies on any cycle.
- IDLE:
  - On a tick where the synchronised line is 0 and the previous tick's sample was 1, go to START and set `os_cnt` = 0.
  - A line held low never retriggers the machine.
- START:
  - `os_cnt` increments on each tick.
  - When `os_cnt` = `OVERSAMPLE`/2−1 and the majority is 0: go to DATA, set `os_cnt` = 0, set `bit_cnt` = 0, and set `receive_enable`.
  - When `os_cnt` = `OVERSAMPLE`/2−1 and the majority is 1: pulse `false_start` and go to IDLE.
- DATA:
  - When `os_cnt` = `OVERSAMPLE`−1: pulse `bit_strobe`, with `bit_value` = majority and `bit_index` = `bit_cnt`. Set `os_cnt` = 0.
  - After that strobe, go to STOP if `bit_cnt` = `NBITS`−1; otherwise increment `bit_cnt`.
  - The module tracks an "all data zero" flag over the data bits only.
- STOP:
  - Each stop bit is sampled at `os_cnt` = `OVERSAMPLE`−1.
  - After `STOP_BITS` samples:
    - Pulse `frame_done` and clear `receive_enable`.
    - Go to IDLE.
    - Pulse `framing_error` if any stop sample was 0.
    - Set `break_detect` if framing error and all data bits were 0.
- `char_received` = 1 in START, DATA or STOP:
  - Next state is IDLE and `receive_enable` is 0 on the next edge.
  - No `frame_done` or error pulse is produced.
  - This takes priority over a simultaneous tick event.
- Counters never wrap: `os_cnt` resets to 0 on every bit boundary. `bit_cnt` never exceeds `NBITS`−1.

## Timing
- Reset (async, `reset` = 0):
  - State = IDLE.
  - All outputs = 0, including `bit_index` = 0 and `break_detect` = 0.
  - Synchroniser and history = 1.
  - Deassertion is treated as synchronous to `clk`, taken at the next edge.
- Reset mid-frame aborts immediately; no pulses are emitted.
- All outputs are registered.
- Pulses are high for exactly the one `clk` cycle after the edge that sampled the qualifying tick.
- Input-to-detection latency is `SYNC_STAGES` `clk` cycles plus tick alignment.
- `receive_enable` rises `OVERSAMPLE`/2 ticks after the detected falling edge.
- Strobe for bit k (k counted from the first data bit): at `OVERSAMPLE`/2 + (k+1)·`OVERSAMPLE` ticks after the edge.

## Structure
- Package `uart_rx_pkg`: state enum (IDLE, START, DATA, STOP), `maj3` function, and width constants derived from the parameters.
- Sub-module `uart_rx_sync`: synchroniser, tick-gated 3-sample history, majority output and falling-edge flag.
- The top level holds the FSM, counters and flags.

## Test plan
- Clean frame 0xA5, 8N1, `OVERSAMPLE`=16:
  - 8 `bit_strobe` pulses with `bit_value` 1,0,1,0,0,1,0,1 (LSB first) and `bit_index` 0..7.
  - Then `frame_done`, with no `framing_error`.
  - `receive_enable` stays high throughout.
- 3-tick low glitch on an idle line → `false_start` pulse, `receive_enable` stays 0, no strobes.
- Frame 0x00 with stop bit 0, then the line held low for 20 bit times:
  - `framing_error` and `frame_done` pulse together.
  - `break_detect` is set and no retrigger occurs.
  - `break_detect` clears when the line goes high.
- `PARITY_EN`=1, `STOP_BITS`=2, `DATA_BITS`=7:
  - 8 strobes, the last with `bit_index`=7.
  - `frame_done` arrives exactly 2·16 ticks after the last strobe.
- `char_received` asserted after strobe 3:
  - `receive_enable` is 0 on the next edge, with no further strobes and no `frame_done`.
  - The next valid frame is received correctly.
- `reset` = 0 mid-DATA → all outputs 0 immediately. After release, an immediate full frame decodes correctly.
